// File: rtl/keypad_cmd_encoder_if.sv
// Keypad/command bundle between the matrix keypad front end and its consumer.
// The master side is the encoder; the slave side drives rows and receives commands.
interface keypad_cmd_encoder_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;

  modport master (input row_in, output col_out, output cmd, output cmd_valid, output busy);
  modport slave  (output row_in, input col_out, input cmd, input cmd_valid, input busy);
endinterface

// File: rtl/keypad_cmd_encoder.sv
// 4x4 keypad scanner: synchronises and debounces rows, then emits one
// HOLD_CYCLES-long cmd pulse per accepted keypress.
module keypad_cmd_encoder #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES     = 10,
  parameter logic [3:0]  IDLE_CMD        = 4'b1101
) (
  input logic                  clock,
  input logic                  reset,
  keypad_cmd_encoder_if.master kp
);

  localparam int unsigned MAX_SD  = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_SD > HOLD_CYCLES) ? MAX_SD : HOLD_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    sync1_q, sync2_q;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          valid_q, valid_d;
  logic [1:0]    low_row;
  logic          row_bit;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'd0:    key_code = 4'd1;
      4'd1:    key_code = 4'd2;
      4'd2:    key_code = 4'd3;
      4'd3:    key_code = 4'b1010;
      4'd4:    key_code = 4'd4;
      4'd5:    key_code = 4'd5;
      4'd6:    key_code = 4'd6;
      4'd7:    key_code = 4'b1011;
      4'd8:    key_code = 4'd7;
      4'd9:    key_code = 4'd8;
      4'd10:   key_code = 4'd9;
      4'd11:   key_code = 4'b1100;
      4'd12:   key_code = 4'b1111;
      4'd13:   key_code = 4'd0;
      4'd14:   key_code = 4'b1110;
      default: key_code = 4'b1101;
    endcase
  endfunction

  assign row_bit = sync2_q[row_q];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    valid_d = valid_q;
    // Lowest row index wins when several rows are low
    if (!sync2_q[0])      low_row = 2'd0;
    else if (!sync2_q[1]) low_row = 2'd1;
    else if (!sync2_q[2]) low_row = 2'd2;
    else                  low_row = 2'd3;

    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (sync2_q != 4'hF) begin
            state_d = DEBOUNCE;
            row_d   = low_row;
            cnt_d   = '0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!row_bit) begin
          if (cnt_q == DEB_LAST) begin
            state_d = EMIT;
            cnt_d   = '0;
            cmd_d   = key_code(row_q, col_q);
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          cnt_d   = '0;
          div_d   = '0;
          col_d   = col_q + 2'd1;
        end
      end
      EMIT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
          cmd_d   = IDLE_CMD;
          valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (row_bit) begin
          if (cnt_q == DEB_LAST) begin
            state_d = SCAN;
            cnt_d   = '0;
            div_d   = '0;
            col_d   = col_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SCAN;
      sync1_q <= '1;
      sync2_q <= '1;
      col_q   <= '0;
      row_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      cmd_q   <= IDLE_CMD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= kp.row_in;
      sync2_q <= sync1_q;
      col_q   <= col_d;
      row_q   <= row_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
    end
  end

  assign kp.col_out   = ~(4'b0001 << col_q);
  assign kp.cmd       = cmd_q;
  assign kp.cmd_valid = valid_q;
  assign kp.busy      = (state_q != SCAN);

endmodule

// File: tb/tb_keypad_cmd_encoder.sv
// Bench for keypad_cmd_encoder: models a physical 4x4 keypad and checks the
// ordered list of emitted command pulses against the keys pressed.
module tb_keypad_cmd_encoder;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 8;
  localparam int unsigned HOLD     = 10;
  localparam logic [3:0]  IDLE     = 4'b1101;
  localparam int          LAT      = 4 * SCAN_DIV + 2 + DEB + 1;
  localparam logic [3:0]  KEYMAP [16] = '{4'd1, 4'd2, 4'd3, 4'b1010,
                                          4'd4, 4'd5, 4'd6, 4'b1011,
                                          4'd7, 4'd8, 4'd9, 4'b1100,
                                          4'b1111, 4'd0, 4'b1110, 4'b1101};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  row_drive;

  keypad_cmd_encoder_if kif ();

  keypad_cmd_encoder #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .IDLE_CMD(IDLE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .kp(kif.master)
  );

  always #5 clock = ~clock;

  // Pressed key shorts its row to the driven-low column; rows are pulled up
  always_comb begin
    row_drive = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.col_out[c]) row_drive[r] = 1'b0;
  end
  assign kif.row_in = row_drive;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int press_cyc = 0;
  bit lat_armed = 0;
  bit in_pulse = 0;
  logic [3:0] pulse_code;
  int pulse_len = 0;
  logic [3:0] got [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    check("col_one_cold", 32'($countones(~kif.col_out)), 32'd1);
    if (kif.cmd_valid === 1'b1) begin
      check("busy_in_pulse", {31'd0, kif.busy}, 32'd1);
      if (!in_pulse) begin
        in_pulse   = 1;
        pulse_code = kif.cmd;
        pulse_len  = 1;
        if (lat_armed) begin
          check("press_latency_ok", {31'd0, (cyc - press_cyc) <= LAT}, 32'd1);
          lat_armed = 0;
        end
      end else begin
        check("pulse_code_stable", {28'd0, kif.cmd}, {28'd0, pulse_code});
        pulse_len++;
      end
    end else begin
      check("cmd_idle", {28'd0, kif.cmd}, {28'd0, IDLE});
      if (in_pulse) begin
        check("pulse_len", pulse_len, HOLD);
        got.push_back(pulse_code);
        in_pulse = 0;
      end
    end
  endtask

  task automatic expect_codes(input string tag, input logic [3:0] code, input int n);
    check({tag, "_count"}, got.size(), n);
    if (n == 1 && got.size() == 1)
      check({tag, "_code"}, {28'd0, got[0]}, {28'd0, code});
    got.delete();
  endtask

  task automatic press_release(input int idx, input int hold, input int gap);
    keys[idx] = 1'b1;
    press_cyc = cyc;
    lat_armed = 1;
    repeat (hold) tick();
    keys = '0;
    repeat (gap) tick();
    expect_codes("key", KEYMAP[idx], 1);
  endtask

  initial begin
    int seq [6];
    int idx;
    bit found;
    seq = '{0, 1, 2, 3, 0, 14};

    // Reset, then idle scanning
    repeat (2) tick();
    tick();
    reset = 1'b0;
    check("rst_col", {28'd0, kif.col_out}, 32'hE);
    check("rst_cmd", {28'd0, kif.cmd}, {28'd0, IDLE});
    check("rst_valid", {31'd0, kif.cmd_valid}, 32'd0);
    check("rst_busy", {31'd0, kif.busy}, 32'd0);
    for (int t = 1; t <= 100; t++) begin
      tick();
      check("idle_col", {28'd0, kif.col_out}, {28'd0, ~(4'b0001 << ((t / SCAN_DIV) % 4))});
      check("idle_busy", {31'd0, kif.busy}, 32'd0);
    end
    got.delete();

    // Single key "1"
    press_release(0, 60, 30);

    // Fixed sequence 1,2,3,+,1,=
    foreach (seq[i]) press_release(seq[i], $urandom_range(40, 70), $urandom_range(20, 40));

    // Random keys
    for (int k = 0; k < 10; k++) begin
      idx = $urandom_range(0, 15);
      press_release(idx, $urandom_range(40, 70), $urandom_range(20, 40));
    end

    // Bouncing "2", then stable
    for (int i = 0; i < 20; i++) begin
      keys[1] = ((i / 3) % 2) == 0;
      tick();
    end
    check("bounce_no_pulse", {31'd0, in_pulse} + 32'(got.size()), 32'd0);
    keys[1] = 1'b1;
    repeat (50) tick();
    keys = '0;
    repeat (30) tick();
    expect_codes("bounce", 4'd2, 1);

    // "5" held, "9" added, both released: only "5"
    keys[5] = 1'b1;
    repeat (40) tick();
    keys[10] = 1'b1;
    repeat (30) tick();
    keys = '0;
    repeat (30) tick();
    expect_codes("rollover", 4'd5, 1);
    press_release(10, 50, 30);

    // Reset during emission of "="
    keys[14] = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (in_pulse && pulse_len == 4) found = 1;
    end
    check("emit_reached", {31'd0, found}, 32'd1);
    in_pulse = 0;
    got.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_cmd", {28'd0, kif.cmd}, {28'd0, IDLE});
    check("midrst_valid", {31'd0, kif.cmd_valid}, 32'd0);
    check("midrst_col", {28'd0, kif.col_out}, 32'hE);
    check("midrst_busy", {31'd0, kif.busy}, 32'd0);
    press_cyc = cyc;
    lat_armed = 1;
    repeat (60) tick();
    keys = '0;
    repeat (30) tick();
    expect_codes("reemit", 4'b1110, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
